// File: rtl/canvas_fetch_sched_if.sv
// Bus bundle for canvas_fetch_sched: drawing writer, single-port VRAM and line-buffer write port.
// The master modport is the scheduler side; slave is the VRAM/writer/line-buffer side.
interface canvas_fetch_sched_if #(
    parameter int unsigned ADDRW = 16,
    parameter int unsigned WORDW = 32,
    parameter int unsigned LBAW  = 6
);
    logic             wr_req;
    logic [ADDRW-1:0] wr_addr;
    logic [WORDW-1:0] wr_data;
    logic             wr_ack;

    logic [ADDRW-1:0] vram_addr;
    logic             vram_we;
    logic [WORDW-1:0] vram_wdata;
    logic [WORDW-1:0] vram_rdata;

    logic             lb_we;
    logic             lb_bank;
    logic [LBAW-1:0]  lb_addr;
    logic [WORDW-1:0] lb_data;

    modport master (
        input  wr_req, wr_addr, wr_data, vram_rdata,
        output wr_ack, vram_addr, vram_we, vram_wdata, lb_we, lb_bank, lb_addr, lb_data
    );

    modport slave (
        output wr_req, wr_addr, wr_data, vram_rdata,
        input  wr_ack, vram_addr, vram_we, vram_wdata, lb_we, lb_bank, lb_addr, lb_data
    );
endinterface

// File: rtl/canvas_fetch_sched.sv
// Canvas VRAM scheduler: bursts one canvas line per scaled line boundary into a double-buffered
// line buffer, sharing the single VRAM port with a drawing writer.
module canvas_fetch_sched #(
    parameter int unsigned CANV_BPP    = 4,
    parameter int unsigned CANV_WIDTH  = 336,
    parameter int unsigned CANV_HEIGHT = 192,
    parameter int unsigned CANV_SCALE  = 2,
    parameter int unsigned WORDW       = 32,
    parameter int unsigned ADDRW       = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start_i,
    input  logic                line_req_i,
    canvas_fetch_sched_if.master bus,
    output logic                disp_bank_o,
    output logic                fetch_busy_o,
    output logic                underrun_o
);
    localparam int unsigned WPL = CANV_WIDTH * CANV_BPP / WORDW;
    localparam int unsigned IW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned SCW = (CANV_SCALE > 1) ? $clog2(CANV_SCALE) : 1;
    localparam int unsigned CYW = $clog2(CANV_HEIGHT + 1);
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);

    localparam logic [IW-1:0]    LastIdx  = IW'(WPL - 1);
    localparam logic [SCW-1:0]   LastSc   = SCW'(CANV_SCALE - 1);
    localparam logic [CYW-1:0]   Height   = CYW'(CANV_HEIGHT);
    localparam logic [ADDRW-1:0] Wpl      = ADDRW'(WPL);
    localparam logic [ADDRW-1:0] BaseAddr = ADDRW'(BASE_ADDR);
    localparam logic [BW-1:0]    MaxBurst = BW'(MAX_BURST);

    typedef enum logic {StIdle, StFetch} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [ADDRW-1:0] line_base_q, line_base_d;
    logic [CYW-1:0]   cy_q, cy_d;
    logic [SCW-1:0]   sc_q, sc_d;
    logic             fill_bank_q, fill_bank_d;
    logic             disp_bank_q, disp_bank_d;
    logic             underrun_q, underrun_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [ADDRW-1:0] addr_hold_q;
    logic             lb_we_q, lb_bank_q;
    logic [IW-1:0]    lb_idx_q;

    logic             restart, grant_wr, rd_issue, fetch_busy;
    logic [CYW:0]     cy_inc;

    assign cy_inc     = {1'b0, cy_q} + (CYW + 1)'(1);
    assign fetch_busy = (state_q == StFetch) | lb_we_q;
    // The slot of an aborting cycle is left unused so no stale read lands in a swapped bank.
    assign restart    = frame_start_i | (line_req_i & (sc_q == '0));
    assign grant_wr   = bus.wr_req & ((state_q != StFetch) | (burst_q == MaxBurst));
    assign rd_issue   = (state_q == StFetch) & ~grant_wr & ~restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        line_base_d = line_base_q;
        cy_d        = cy_q;
        sc_d        = sc_q;
        fill_bank_d = fill_bank_q;
        disp_bank_d = disp_bank_q;
        underrun_d  = underrun_q;
        if (frame_start_i) begin
            state_d     = StFetch;
            i_d         = '0;
            cy_d        = '0;
            sc_d        = '0;
            line_base_d = BaseAddr;
        end else if (line_req_i) begin
            if (sc_q == '0) begin
                if (fetch_busy) underrun_d = 1'b1;
                disp_bank_d = fill_bank_q;
                fill_bank_d = ~fill_bank_q;
                if (cy_inc < {1'b0, Height}) begin
                    state_d     = StFetch;
                    i_d         = '0;
                    line_base_d = line_base_q + Wpl;
                end else begin
                    state_d = StIdle;
                end
            end
            if (sc_q == LastSc) begin
                sc_d = '0;
                if (cy_q != Height) cy_d = cy_q + CYW'(1);
            end else begin
                sc_d = sc_q + SCW'(1);
            end
        end else if (rd_issue) begin
            if (i_q == LastIdx) begin
                state_d = StIdle;
            end else begin
                i_d = i_q + IW'(1);
            end
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (grant_wr || !bus.wr_req) begin
            burst_d = '0;
        end else if (rd_issue) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q         <= '0;
            line_base_q <= '0;
            cy_q        <= '0;
            sc_q        <= '0;
            fill_bank_q <= 1'b1;
            disp_bank_q <= 1'b0;
            underrun_q  <= 1'b0;
            burst_q     <= '0;
            addr_hold_q <= '0;
            lb_we_q     <= 1'b0;
            lb_bank_q   <= 1'b0;
            lb_idx_q    <= '0;
        end else begin
            i_q         <= i_d;
            line_base_q <= line_base_d;
            cy_q        <= cy_d;
            sc_q        <= sc_d;
            fill_bank_q <= fill_bank_d;
            disp_bank_q <= disp_bank_d;
            underrun_q  <= underrun_d;
            burst_q     <= burst_d;
            addr_hold_q <= bus.vram_addr;
            lb_we_q     <= rd_issue;
            if (rd_issue) begin
                lb_bank_q <= fill_bank_q;
                lb_idx_q  <= i_q;
            end
        end
    end

    always_comb begin
        bus.wr_ack     = grant_wr;
        bus.vram_we    = grant_wr;
        bus.vram_wdata = grant_wr ? bus.wr_data : '0;
        if (grant_wr) begin
            bus.vram_addr = bus.wr_addr;
        end else if (rd_issue) begin
            bus.vram_addr = line_base_q + ADDRW'(i_q);
        end else begin
            bus.vram_addr = addr_hold_q;
        end
        bus.lb_we     = lb_we_q;
        bus.lb_bank   = lb_bank_q;
        bus.lb_addr   = lb_idx_q;
        bus.lb_data   = lb_we_q ? bus.vram_rdata : '0;
        disp_bank_o   = disp_bank_q;
        fetch_busy_o  = fetch_busy;
        underrun_o    = underrun_q;
    end
endmodule

// File: tb/tb_canvas_fetch_sched.sv
// Directed bench for canvas_fetch_sched with a 4-word line, 3 canvas lines, scale 2.
// VRAM model returns the read address as data one cycle after the read.
module tb_canvas_fetch_sched;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned LBAW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic line_req = 1'b0;
    logic disp_bank, fetch_busy, underrun;
    int   n_checks = 0;
    int   n_pass = 0;

    canvas_fetch_sched_if #(.ADDRW(AW), .WORDW(DW), .LBAW(LBAW)) bus ();

    canvas_fetch_sched #(
        .CANV_BPP(4), .CANV_WIDTH(32), .CANV_HEIGHT(3), .CANV_SCALE(2),
        .WORDW(DW), .ADDRW(AW), .BASE_ADDR(32'h100), .MAX_BURST(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start_i(frame_start),
        .line_req_i(line_req),
        .bus(bus),
        .disp_bank_o(disp_bank),
        .fetch_busy_o(fetch_busy),
        .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.vram_rdata <= {16'h0, bus.vram_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.wr_ack, bus.vram_we, bus.vram_addr, bus.vram_wdata, bus.lb_we, bus.lb_bank,
             bus.lb_addr, bus.lb_data, fetch_busy, disp_bank, underrun} !== '0)
            $display("FAIL reset_outputs got addr=%h we=%b lb_we=%b busy=%b disp=%b und=%b want all 0",
                     bus.vram_addr, bus.vram_we, bus.lb_we, fetch_busy, disp_bank, underrun);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({fetch_busy, bus.lb_we, bus.vram_we} !== 3'b000)
            $display("FAIL reset_release_idle got busy=%b lb_we=%b we=%b want 000",
                     fetch_busy, bus.lb_we, bus.vram_we);
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        int  busy_n = 0;
        logic exp_lb;
        step();
        frame_start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            frame_start = 1'b0;
            @(negedge clk);
            if (fetch_busy) busy_n++;
            if (k < 4) begin
                n_checks++;
                if (bus.vram_addr !== AW'(32'h100 + k) || bus.vram_we !== 1'b0)
                    $display("FAIL first_fetch_read k=%0d got addr=%h we=%b want addr=%h we=0",
                             k, bus.vram_addr, bus.vram_we, AW'(32'h100 + k));
                else n_pass++;
            end
            exp_lb = (k >= 1 && k <= 4);
            n_checks++;
            if (bus.lb_we !== exp_lb)
                $display("FAIL first_fetch_lb_we k=%0d got %b want %b", k, bus.lb_we, exp_lb);
            else n_pass++;
            if (exp_lb) begin
                n_checks++;
                if ({bus.lb_bank, bus.lb_addr, bus.lb_data} !==
                    {1'b1, LBAW'(k - 1), DW'(32'h100 + k - 1)})
                    $display("FAIL first_fetch_lb k=%0d got bank=%b addr=%0d data=%h want bank=1 addr=%0d data=%h",
                             k, bus.lb_bank, bus.lb_addr, bus.lb_data, k - 1, 32'h100 + k - 1);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_n != 5) $display("FAIL first_fetch_busy_cycles got %0d want 5", busy_n);
        else n_pass++;
    endtask

    task automatic test_line_seq();
        logic [5:0] exp_disp = 6'b110011;
        logic       exp_fetch;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (8) step();
        for (int j = 0; j < 6; j++) begin
            line_req = 1'b1;
            step();
            line_req = 1'b0;
            @(negedge clk);
            exp_fetch = (j == 0 || j == 2);
            n_checks++;
            if (disp_bank !== exp_disp[j] || fetch_busy !== exp_fetch)
                $display("FAIL line_seq_%0d got disp=%b busy=%b want disp=%b busy=%b",
                         j, disp_bank, fetch_busy, exp_disp[j], exp_fetch);
            else n_pass++;
            if (exp_fetch) begin
                n_checks++;
                if (bus.vram_addr !== ((j == 0) ? 16'h104 : 16'h108))
                    $display("FAIL line_seq_addr_%0d got %h want %h", j, bus.vram_addr,
                             (j == 0) ? 16'h104 : 16'h108);
                else n_pass++;
                step();
                @(negedge clk);
                n_checks++;
                if (bus.lb_we !== 1'b1 || bus.lb_bank !== ((j == 0) ? 1'b0 : 1'b1))
                    $display("FAIL line_seq_bank_%0d got lb_we=%b bank=%b want lb_we=1 bank=%b",
                             j, bus.lb_we, bus.lb_bank, (j == 0) ? 1'b0 : 1'b1);
                else n_pass++;
            end
            repeat (18) step();
        end
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL line_seq_underrun got %b want 0", underrun);
        else n_pass++;
    endtask

    task automatic test_write_arb();
        logic [AW-1:0] exp_addr [5];
        logic [4:0]    exp_we = 5'b00100;
        int            lb_n = 0;
        int            ack_n = 0;
        logic          seen;
        exp_addr[0] = 16'h100;
        exp_addr[1] = 16'h101;
        exp_addr[2] = 16'h020;
        exp_addr[3] = 16'h102;
        exp_addr[4] = 16'h103;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h20;
        bus.wr_data = 32'hABCD;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.lb_we) lb_n++;
            if (bus.wr_ack) ack_n++;
            if (k < 5) begin
                n_checks++;
                if (bus.vram_addr !== exp_addr[k] || bus.vram_we !== exp_we[k] ||
                    bus.wr_ack !== exp_we[k])
                    $display("FAIL write_arb_slot_%0d got addr=%h we=%b ack=%b want addr=%h we=%b ack=%b",
                             k, bus.vram_addr, bus.vram_we, bus.wr_ack, exp_addr[k], exp_we[k],
                             exp_we[k]);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (bus.vram_wdata !== 32'hABCD)
                    $display("FAIL write_arb_wdata got %h want 0000abcd", bus.vram_wdata);
                else n_pass++;
            end
            seen = bus.wr_ack;
            step();
            if (seen) bus.wr_req = 1'b0;
        end
        n_checks++;
        if (lb_n != 4 || ack_n != 1)
            $display("FAIL write_arb_counts got lb_we=%0d ack=%0d want 4 and 1", lb_n, ack_n);
        else n_pass++;
        repeat (3) step();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h30;
        bus.wr_data = 32'h55;
        @(negedge clk);
        n_checks++;
        if ({bus.wr_ack, bus.vram_we, bus.vram_addr, bus.vram_wdata} !== {2'b11, 16'h30, 32'h55})
            $display("FAIL idle_write got ack=%b we=%b addr=%h data=%h want 1 1 0030 00000055",
                     bus.wr_ack, bus.vram_we, bus.vram_addr, bus.vram_wdata);
        else n_pass++;
        step();
        bus.wr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.wr_ack, bus.vram_we, bus.vram_addr} !== {2'b00, 16'h30})
            $display("FAIL idle_hold got ack=%b we=%b addr=%h want 0 0 0030",
                     bus.wr_ack, bus.vram_we, bus.vram_addr);
        else n_pass++;
        repeat (4) step();
    endtask

    task automatic test_underrun();
        line_req = 1'b1;
        repeat (3) step();
        line_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({underrun, fetch_busy, disp_bank, bus.vram_addr} !== {3'b111, 16'h108})
            $display("FAIL underrun_set got und=%b busy=%b disp=%b addr=%h want 1 1 1 0108",
                     underrun, fetch_busy, disp_bank, bus.vram_addr);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if ({bus.lb_we, bus.lb_bank, bus.lb_addr, bus.lb_data} !== {2'b10, 2'd0, 32'h108})
            $display("FAIL underrun_restart got lb_we=%b bank=%b addr=%0d data=%h want 1 0 0 00000108",
                     bus.lb_we, bus.lb_bank, bus.lb_addr, bus.lb_data);
        else n_pass++;
        repeat (20) step();
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL underrun_sticky got %b want 1", underrun);
        else n_pass++;
    endtask

    task automatic test_fs_lr_same();
        frame_start = 1'b1;
        line_req    = 1'b1;
        step();
        frame_start = 1'b0;
        line_req    = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({disp_bank, fetch_busy, bus.vram_addr} !== {2'b11, 16'h100})
            $display("FAIL fs_lr_fetch got disp=%b busy=%b addr=%h want 1 1 0100",
                     disp_bank, fetch_busy, bus.vram_addr);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if ({bus.lb_we, bus.lb_bank, bus.lb_addr} !== {2'b10, 2'd0})
            $display("FAIL fs_lr_bank got lb_we=%b bank=%b addr=%0d want 1 0 0",
                     bus.lb_we, bus.lb_bank, bus.lb_addr);
        else n_pass++;
        repeat (10) step();
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({disp_bank, bus.vram_addr} !== {1'b0, 16'h104})
            $display("FAIL fs_lr_sc_zero got disp=%b addr=%h want 0 0104", disp_bank, bus.vram_addr);
        else n_pass++;
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        int lb_n = 0;
        int busy_n = 0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.wr_ack, bus.vram_we, bus.vram_addr, bus.lb_we, bus.lb_bank, bus.lb_addr,
             bus.lb_data, fetch_busy, disp_bank, underrun} !== '0)
            $display("FAIL reset_mid_outputs got addr=%h lb_we=%b busy=%b disp=%b und=%b want all 0",
                     bus.vram_addr, bus.lb_we, fetch_busy, disp_bank, underrun);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.lb_we) lb_n++;
            if (fetch_busy) busy_n++;
        end
        n_checks++;
        if (lb_n != 0 || busy_n != 0)
            $display("FAIL reset_mid_quiet got lb_we=%0d busy=%0d want 0 and 0", lb_n, busy_n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_line_seq();
        test_write_arb();
        test_underrun();
        test_fs_lr_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/canvas_fetch_sched.md
Name: canvas_fetch_sched

Overview:
Schedules single-port canvas VRAM between the display line fetcher and one drawing-write requester. On each canvas line boundary, bursts one canvas line of words from VRAM into one half of a double-buffered line buffer. Honours vertical canvas scaling, so each canvas line is fetched once and shown CANV_SCALE times. Sits between the bitmap VRAM and the canvas/palette display path.

Parameters:
CANV_BPP, 4, bits per canvas pixel.
CANV_WIDTH, 336, canvas width in pixels.
CANV_HEIGHT, 192, canvas height in lines.
CANV_SCALE, 2, display lines per canvas line (>=1).
WORDW, 32, VRAM word width; CANV_WIDTH*CANV_BPP must be a multiple of WORDW.
ADDRW, 16, VRAM word address width.
BASE_ADDR, 0, VRAM word address of canvas line 0.
MAX_BURST, 8, maximum consecutive fetch reads while a write is pending.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
frame_start  input  1  one-cycle pulse in vertical blanking, before the first window line.
line_req  input  1  one-cycle pulse before each window display line starts; the first follows frame_start.
wr_req  input  1  writer request; wr_addr and wr_data are held stable until wr_ack.
wr_addr  input  ADDRW  writer word address.
wr_data  input  WORDW  writer data.
wr_ack  output  1  one-cycle pulse in the cycle the write is issued to VRAM.
vram_addr  output  ADDRW  VRAM word address.
vram_we  output  1  VRAM write enable.
vram_wdata  output  WORDW  VRAM write data.
vram_rdata  input  WORDW  VRAM read data, valid one cycle after the read is issued.
lb_we  output  1  line buffer write enable.
lb_bank  output  1  line buffer bank being written.
lb_addr  output  $clog2(WPL)  word index within the line buffer.
lb_data  output  WORDW  line buffer write data.
disp_bank  output  1  line buffer bank the display reads.
fetch_busy  output  1  high while a line fetch is outstanding.
underrun  output  1  sticky flag: a fetch was incomplete when needed.

Behaviour:
- Reset is asynchronous and active-low. It drives all outputs to 0, sets fill_bank=1, puts the FSM in IDLE, and clears cy, sc, the burst counter and the line base.
- WPL = CANV_WIDTH*CANV_BPP/WORDW (42 at defaults).
- Registers:
  - cy: next canvas line.
  - sc: scale count, 0..CANV_SCALE-1.
  - fill_bank: bank being filled.
  - line_base: VRAM address of the fetching line; advanced by adding WPL, no multiplier.
  - word index i.
- FSM states: IDLE and FETCH.
  - FETCH issues reads line_base+i, i=0..WPL-1, one per granted slot.
  - Last read issued -> IDLE.
  - fetch_busy is high from FETCH entry until the final lb_we cycle inclusive.
- Line buffer writes:
  - Each read issued in cycle t gives lb_we=1 in cycle t+1.
  - In that cycle: lb_addr=i, lb_bank=fill_bank, lb_data=vram_rdata.
  - lb_bank and lb_addr come from registered copies of the read-cycle values.
- frame_start:
  - Aborts any fetch; in-flight reads still complete their lb_we.
  - cy<=0, sc<=0, line_base<=BASE_ADDR.
  - Starts a fetch of line 0 into fill_bank. fill_bank is unchanged.
- line_req:
  - If sc==0:
    - If fetch_busy, set underrun and abort the fetch.
    - disp_bank<=fill_bank, then fill_bank<=~fill_bank.
    - If cy+1<CANV_HEIGHT, start a fetch of line cy+1 into the new fill_bank, with line_base+=WPL. Otherwise stay IDLE.
  - Then sc<=(sc==CANV_SCALE-1)?0:sc+1.
  - cy increments when sc wraps.
  - With CANV_SCALE=1, every line_req swaps.
- frame_start and line_req in the same cycle: frame_start wins and line_req is ignored.
- line_req after the last canvas line: swaps continue per the rules above and no fetch starts. Nothing wraps.
- Arbitration, one VRAM access per cycle:
  - Fetch has priority, except when wr_req=1 and burst_cnt==MAX_BURST; then the writer is granted.
  - With no fetch active, wr_req is granted immediately.
  - burst_cnt increments on each fetch read while wr_req=1. It clears on writer grant or when wr_req=0.
- Write grant cycle: vram_we=1, vram_addr=wr_addr, vram_wdata=wr_data, wr_ack=1. A writer stalled by the fetch loses no data.
- Idle cycle: vram_we=0, vram_addr holds its last value.
- underrun is cleared only by reset.
- Mid-fetch reset: everything returns to reset values immediately and no lb_we is issued afterwards.

Test Plan:
Use CANV_WIDTH=32, CANV_BPP=4, WORDW=32 (WPL=4), CANV_HEIGHT=3, CANV_SCALE=2, BASE_ADDR=0x100, MAX_BURST=2.
- Reset then frame_start with VRAM word = address -> reads 0x100..0x103 on consecutive cycles; lb_we on the next 4 cycles with lb_bank=1, lb_addr 0..3, lb_data 0x100..0x103; fetch_busy high 5 cycles.
- frame_start then 6 line_req spaced 20 cycles -> disp_bank 1,1,0,0,1,1; fetches at 0x104 (bank 0) and 0x108 (bank 1); no fetch after line 2; underrun=0.
- Hold wr_req (addr 0x20, data 0xABCD) during a fetch -> reads, reads, write (wr_ack, vram_we, addr 0x20), read, read; 4 lb_we total; writer never lost.
- Second line_req pair spaced only 2 cycles, so the fetch is still busy -> underrun=1 and stays 1; the new fetch restarts at i=0.
- frame_start and line_req in the same cycle -> treated as frame_start only: line 0 fetch, sc=0, disp_bank unchanged.
- rst_n low mid-fetch, at i=2 -> all outputs 0 asynchronously; no lb_we after release until the next frame_start.
